xbar_flow_eval: RTL and testbench
=================================

// Module: xbar_flow_eval
// PURPOSE
// - Sequential, programmable successor of the fixed flow-based crossbar netlists: ROWS x COLS memristor crossbar,
//   each junction programmed with a literal (off / on / x_i / !x_i), evaluated by iterative flow propagation.
// - Input wordline IN_ROW is driven high; f = 1 iff flow reaches wordline out_row under the latched assignment.
// - Sits between the SAT/synthesis driver (loads cell literals, applies assignments) and the result collector.
// PARAMETERS
// - ROWS    4  number of wordlines (>=2)
// - COLS    4  number of bitlines (>=1)
// - NVARS   4  number of Boolean input variables
// - IN_ROW  0  wordline driven with constant 1 during evaluation
// PORTS
// - clk        in   1                 rising-edge clock
// - rst        in   1                 synchronous, active-high reset
// - cfg_we     in   1                 write one junction literal
// - cfg_row    in   $clog2(ROWS)      junction wordline index
// - cfg_col    in   $clog2(COLS)      junction bitline index
// - cfg_lit    in   LIT_W             {mode[1:0], var[$clog2(NVARS)-1:0]}; mode 00 off, 01 on, 10 x, 11 !x
// - start      in   1                 begin evaluation (sampled in IDLE/DONE only)
// - vars       in   NVARS             variable assignment, latched on accepted start
// - out_row    in   $clog2(ROWS)      sensed wordline, latched on accepted start
// - busy       out  1                 high while evaluating
// - done       out  1                 one-cycle pulse when f is valid
// - f          out  1                 flow result; held until next accepted start
// - iters      out  $clog2(ROWS+COLS+1)  propagation steps used by last evaluation
// BEHAVIOUR
// - Reset: state IDLE; all cells = off; busy=0, done=0, f=0, iters=0; reach vectors cleared.
// - Config write: in IDLE/DONE, cfg_we writes cell[cfg_row][cfg_col] at clock edge; ignored while busy.
//   cfg_row>=ROWS or cfg_col>=COLS -> write dropped. var index >=NVARS -> literal evaluates 0.
// - Conduction: cond[r][c] = off:0, on:1, x:vars_q[v], !x:~vars_q[v]; computed from latched vars_q.
// - FSM IDLE->EVAL on start; EVAL->DONE on fixpoint or bound; DONE->EVAL on start, else DONE (idle-equivalent).
// - On accept: vars_q/out_q latched; row_r = one-hot(IN_ROW); col_r = 0; iters=0; busy=1 next cycle.
// - EVAL step (one per cycle): col_n[c] = col_r[c] | OR_r(row_r[r] & cond[r][c]);
//   row_n[r] = row_r[r] | OR_c(col_n[c] & cond[r][c]); registers updated, iters++.
// - Fixpoint: step where row_n==row_r and col_n==col_r -> DONE; that step counts in iters.
// - Bound: after ROWS+COLS steps force DONE (unreachable in theory; guards against bugs).
// - Early exit: if row_n[out_q]==1 -> DONE immediately, f=1.
// - DONE entry: f = row_r[out_q] after final update; done=1 for exactly one cycle; busy=0 same cycle.
// - Latency: start accepted at edge N -> done at edge N+1+k, k = steps (1 <= k <= ROWS+COLS).
// - start while busy: ignored. start asserted in same cycle as done: accepted (back-to-back).
// - out_row==IN_ROW: f=1 after first step (trivial flow).
// - rst mid-EVAL: abort, no done pulse, cells cleared, f=0.
// STRUCTURE
// - Package xbar_pkg: LIT_W function, mode enum {LIT_OFF, LIT_ON, LIT_POS, LIT_NEG}, state enum {IDLE, EVAL, DONE}.
// - Sub-module xbar_cell_array: cell storage + write port + combinational cond[][] from vars_q.
// - Top: FSM, reach registers, step logic, iteration counter, output registers.
// TESTING
// - Reset: pulse rst 2 cycles -> busy=0, done=0, f=0, iters=0; start with no cells written -> f=0, iters=1.
// - 4x4, vars {d,c,b,a}: program cell[0][0]=a, cell[1][0]=c, cell[1][1]=c, cell[2][1]=d; out_row=2;
//   vars=a1 c1 d1 b0 -> f=1; vars with a=0 -> f=0; vars with d=0 -> f=0.
// - Multi-hop path 0->c0->1->c1->2->c2->3 all cells 'on', ROWS=COLS=4, out_row=3 -> f=1, iters=3, done 4 cycles after start.
// - Negated literal: cell[0][0]=!x0, cell[1][0]=on, out_row=1: vars[0]=0 -> f=1; vars[0]=1 -> f=0, iters=1.
// - cfg_we during EVAL dropped (re-run shows old result); start during EVAL ignored; start on done cycle accepted.
// - rst asserted at 2nd EVAL cycle -> no done pulse, f=0, all cells off on subsequent run.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared types and width helpers for the programmable flow-evaluation crossbar.
package xbar_pkg;

    typedef enum logic [1:0] {
        LIT_OFF = 2'b00,
        LIT_ON  = 2'b01,
        LIT_POS = 2'b10,
        LIT_NEG = 2'b11
    } lit_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EVAL = 2'b01,
        DONE = 2'b10
    } state_e;

    // Index width that never collapses to zero bits for single-entry dimensions.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Cell literal width: {mode[1:0], var index}.
    function automatic int lit_w(input int nvars);
        return 2 + idx_w(nvars);
    endfunction

endpackage

// File: rtl/xbar_cell_array.sv
// Junction literal storage with a single write port and per-junction conduction
// derived from the latched variable assignment.
module xbar_cell_array
    import xbar_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int NVARS = 4,
    localparam int RW    = idx_w(ROWS),
    localparam int CW    = idx_w(COLS),
    localparam int VW    = idx_w(NVARS),
    localparam int LIT_W = lit_w(NVARS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [RW-1:0]              wr_row,
    input  logic [CW-1:0]              wr_col,
    input  logic [LIT_W-1:0]           wr_lit,
    input  logic [NVARS-1:0]           vars_q,
    output logic [ROWS-1:0][COLS-1:0]  cond
);

    logic [LIT_W-1:0] cells [ROWS][COLS];
    logic             row_ok;
    logic             col_ok;

    assign row_ok = (32'(wr_row) < 32'(ROWS));
    assign col_ok = (32'(wr_col) < 32'(COLS));

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this storage is reset on purpose -- every junction must read as off after reset.
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    cells[r][c] <= '0;
                end
            end
        end else if (we && row_ok && col_ok) begin
            cells[wr_row][wr_col] <= wr_lit;
        end
    end

    always_comb begin
        lit_mode_e      mode;
        logic [VW-1:0]  vidx;
        logic           vok;
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        cond = '0;
        mode = LIT_OFF;
        vidx = '0;
        vok  = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                mode = lit_mode_e'(cells[r][c][LIT_W-1 -: 2]);
                vidx = cells[r][c][VW-1:0];
                vok  = (32'(vidx) < 32'(NVARS));
                case (mode)
                    LIT_OFF: cond[r][c] = 1'b0;
                    LIT_ON:  cond[r][c] = 1'b1;
                    LIT_POS: cond[r][c] = vok &  vars_q[vidx];
                    LIT_NEG: cond[r][c] = vok & ~vars_q[vidx];
                    default: cond[r][c] = 1'b0;
                endcase
            end
        end
    end

endmodule

// File: rtl/xbar_flow_eval.sv
// Iterative flow evaluation over a programmable crossbar: one wordline/bitline
// propagation step per cycle until the sensed wordline is reached or a fixpoint.
module xbar_flow_eval
    import xbar_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int NVARS  = 4,
    parameter int IN_ROW = 0,
    localparam int RW    = idx_w(ROWS),
    localparam int CW    = idx_w(COLS),
    localparam int LIT_W = lit_w(NVARS),
    localparam int IW    = $clog2(ROWS + COLS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [RW-1:0]     cfg_row,
    input  logic [CW-1:0]     cfg_col,
    input  logic [LIT_W-1:0]  cfg_lit,
    input  logic              start,
    input  logic [NVARS-1:0]  vars,
    input  logic [RW-1:0]     out_row,
    output logic              busy,
    output logic              done,
    output logic              f,
    output logic [IW-1:0]     iters
);

    localparam logic [ROWS-1:0] IN_MASK   = ROWS'(1) << IN_ROW;
    localparam logic [IW-1:0]   MAX_STEPS = IW'(ROWS + COLS);

    state_e                    state;
    logic                      pend;
    logic [NVARS-1:0]          vars_q;
    logic [RW-1:0]             out_q;
    logic [ROWS-1:0]           row_r;
    logic [ROWS-1:0]           row_n;
    logic [COLS-1:0]           col_r;
    logic [COLS-1:0]           col_n;
    logic [ROWS-1:0][COLS-1:0] cond;
    logic                      stop;

    xbar_cell_array #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .NVARS (NVARS)
    ) u_cells (
        .clk    (clk),
        .rst    (rst),
        .we     (cfg_we && !busy),
        .wr_row (cfg_row),
        .wr_col (cfg_col),
        .wr_lit (cfg_lit),
        .vars_q (vars_q),
        .cond   (cond)
    );

    // Bitlines see this cycle's wordlines; wordlines see the freshly updated bitlines.
    always_comb begin
        col_n = col_r;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                col_n[c] = col_n[c] | (row_r[r] & cond[r][c]);
            end
        end
        row_n = row_r;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                row_n[r] = row_n[r] | (col_n[c] & cond[r][c]);
            end
        end
    end

    assign stop = row_n[out_q]
               || ((row_n == row_r) && (col_n == col_r))
               || (iters == MAX_STEPS - 1'b1);

    // pend marks the first DONE cycle, where f is resolved from the final reach vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pend   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            f      <= 1'b0;
            iters  <= '0;
            vars_q <= '0;
            out_q  <= '0;
            row_r  <= '0;
            col_r  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (pend) begin
                        f    <= row_r[out_q];
                        done <= 1'b1;
                        busy <= 1'b0;
                        pend <= 1'b0;
                    end else if (start) begin
                        vars_q <= vars;
                        out_q  <= out_row;
                        row_r  <= IN_MASK;
                        col_r  <= '0;
                        iters  <= '0;
                        busy   <= 1'b1;
                        state  <= EVAL;
                    end
                end
                EVAL: begin
                    row_r <= row_n;
                    col_r <= col_n;
                    iters <= iters + 1'b1;
                    if (stop) begin
                        state <= DONE;
                        pend  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xbar_flow_eval.sv
// Randomized and directed bench for xbar_flow_eval against a set-based flow model.
module tb_xbar_flow_eval;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_row;
    logic [1:0] cfg_col;
    logic [3:0] cfg_lit;
    logic       start;
    logic [3:0] vars;
    logic [1:0] out_row;
    logic       busy;
    logic       done;
    logic       f;
    logic [3:0] iters;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] mdl [4][4];
    int last_f, last_i, last_cyc;

    xbar_flow_eval #(
        .ROWS   (4),
        .COLS   (4),
        .NVARS  (4),
        .IN_ROW (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_we  (cfg_we),
        .cfg_row (cfg_row),
        .cfg_col (cfg_col),
        .cfg_lit (cfg_lit),
        .start   (start),
        .vars    (vars),
        .out_row (out_row),
        .busy    (busy),
        .done    (done),
        .f       (f),
        .iters   (iters)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] mk_lit(input int mode, input int v);
        logic [3:0] l;
        l[3:2] = 2'(mode);
        l[1:0] = 2'(v);
        return l;
    endfunction

    function automatic bit lit_val(input logic [3:0] l, input logic [3:0] vv);
        case (l[3:2])
            2'd0:    return 1'b0;
            2'd1:    return 1'b1;
            2'd2:    return vv[l[1:0]];
            default: return !vv[l[1:0]];
        endcase
    endfunction

    // Grow the reached wordline/bitline sets one step at a time until the sensed
    // wordline is in the set, nothing new is reached, or the step bound is hit.
    task automatic model_eval(input logic [3:0] vv, input int o, output int ef, output int ek);
        bit [3:0] rset, cset, rnx, cnx;
        rset = 4'b0001;
        cset = 4'b0000;
        ef = 0;
        ek = 0;
        for (int step = 1; step <= 8; step++) begin
            cnx = cset;
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (rset[r] && lit_val(mdl[r][c], vv)) cnx[c] = 1'b1;
            rnx = rset;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (cnx[c] && lit_val(mdl[r][c], vv)) rnx[r] = 1'b1;
            ek = step;
            if (rnx[o] || (rnx == rset && cnx == cset) || step == 8) begin
                ef = int'(rnx[o]);
                break;
            end
            rset = rnx;
            cset = cnx;
        end
    endtask

    task automatic write_cell(input int r, input int c, input logic [3:0] l);
        cfg_we  = 1'b1;
        cfg_row = 2'(r);
        cfg_col = 2'(c);
        cfg_lit = l;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        mdl[r][c] = l;
    endtask

    task automatic clear_cells();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                write_cell(r, c, 4'h0);
    endtask

    task automatic program_chain();
        clear_cells();
        write_cell(0, 0, mk_lit(1, 0));
        write_cell(1, 0, mk_lit(1, 0));
        write_cell(1, 1, mk_lit(1, 0));
        write_cell(2, 1, mk_lit(1, 0));
        write_cell(2, 2, mk_lit(1, 0));
        write_cell(3, 2, mk_lit(1, 0));
    endtask

    task automatic launch(input logic [3:0] vv, input int o);
        start   = 1'b1;
        vars    = vv;
        out_row = 2'(o);
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("done_low_after_start", int'(done), 0);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        last_cyc = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1 last_cyc++;
            if (done) seen = 1'b1;
        end
        check("done_seen", int'(seen), 1);
        check("busy_low_at_done", int'(busy), 0);
        last_f = int'(f);
        last_i = int'(iters);
    endtask

    task automatic run_model(input string tag, input logic [3:0] vv, input int o);
        int ef, ek;
        model_eval(vv, o, ef, ek);
        launch(vv, o);
        wait_done();
        check({tag, "_f"}, last_f, ef);
        check({tag, "_iters"}, last_i, ek);
        check({tag, "_latency"}, last_cyc, ek + 1);
    endtask

    initial begin
        int done_cnt;
        rst = 1'b1; cfg_we = 1'b0; cfg_row = '0; cfg_col = '0; cfg_lit = '0;
        start = 1'b0; vars = '0; out_row = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mdl[r][c] = 4'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_f", int'(f), 0);
        check("rst_iters", int'(iters), 0);

        run_model("empty", 4'b0000, 2);
        check("empty_iters_const", last_i, 1);

        // vars = {d,c,b,a}
        write_cell(0, 0, mk_lit(2, 0));
        write_cell(1, 0, mk_lit(2, 2));
        write_cell(1, 1, mk_lit(2, 2));
        write_cell(2, 1, mk_lit(2, 3));
        run_model("acd_on", 4'b1101, 2);
        check("acd_on_const", last_f, 1);
        run_model("a_off", 4'b1100, 2);
        check("a_off_const", last_f, 0);
        run_model("d_off", 4'b0101, 2);
        check("d_off_const", last_f, 0);

        program_chain();
        run_model("chain", 4'b0000, 3);
        check("chain_f_const", last_f, 1);
        check("chain_iters_const", last_i, 3);
        check("chain_latency_const", last_cyc, 4);
        run_model("trivial", 4'($urandom_range(0, 15)), 0);
        check("trivial_iters_const", last_i, 1);

        clear_cells();
        write_cell(0, 0, mk_lit(3, 0));
        write_cell(1, 0, mk_lit(1, 0));
        run_model("neg_x0", 4'b0000, 1);
        check("neg_x0_const", last_f, 1);
        run_model("neg_x1", 4'b0001, 1);
        check("neg_x1_f_const", last_f, 0);
        check("neg_x1_iters_const", last_i, 1);

        // Write while busy must be dropped.
        program_chain();
        launch(4'b0000, 3);
        cfg_we = 1'b1; cfg_row = 2'd3; cfg_col = 2'd2; cfg_lit = 4'h0;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        wait_done();
        check("busy_write_run_f", last_f, 1);
        run_model("after_drop", 4'b0000, 3);

        // Start while busy must be ignored.
        launch(4'b0000, 3);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        check("ign_start_iters", last_i, 3);
        @(posedge clk);
        #1;
        check("ign_start_busy", int'(busy), 0);
        check("ign_start_done", int'(done), 0);

        // Back-to-back: start held during the done cycle.
        launch(4'b0000, 3);
        wait_done();
        run_model("b2b", 4'b0000, 1);

        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        write_cell(r, c, mk_lit($urandom_range(0, 3), $urandom_range(0, 3)));
            end
            run_model("rand", 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        // Reset in the second EVAL cycle aborts the run and clears all cells.
        program_chain();
        launch(4'b0000, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 if (done) done_cnt++;
        end
        check("rst_abort_no_done", done_cnt, 0);
        check("rst_abort_f", int'(f), 0);
        check("rst_abort_busy", int'(busy), 0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mdl[r][c] = 4'h0;
        run_model("after_rst", 4'b0000, 3);
        check("after_rst_f_const", last_f, 0);
        check("after_rst_iters_const", last_i, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
